// File: rtl/vector_writeback.sv
// Writeback stage: 2-entry in-order buffer between the SIMD execution stage and the
// vector register file write port, plus the architectural per-lane carry flag register.
module vector_writeback #(
  parameter int BITS_ARRAY = 64,
  parameter int BITS_DATA  = 8,
  parameter int BITS_ADDR  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      exValid,
  output logic                      exReady,
  input  logic [BITS_ARRAY-1:0]     executionResult,
  input  logic [BITS_DATA-1:0]      carryTotal,
  input  logic [BITS_ADDR-1:0]      exDest,
  input  logic                      exRegWrite,
  input  logic                      exCarryWrite,
  input  logic                      carryClear,
  output logic [BITS_DATA-1:0]      auxCarry,
  output logic                      rfWriteEnable,
  output logic [BITS_ADDR-1:0]      rfWriteAddr,
  output logic [BITS_ARRAY-1:0]     rfWriteData,
  input  logic                      rfReady,
  output logic [(1<<BITS_ADDR)-1:0] pendingMask
);

  logic [BITS_ARRAY-1:0] data_q [2];
  logic [BITS_ADDR-1:0]  dest_q [2];
  logic                  rw_q   [2];
  logic                  head;
  logic [1:0]            count;
  logic [BITS_DATA-1:0]  carry_reg;

  logic push, pop, wr_idx;
  logic [1:0] entry_valid;

  assign exReady = (count != 2'd2);
  assign push    = exValid && exReady;
  // Non-writing entries drain without waiting on the register file.
  assign pop     = (count != 2'd0) && (!rw_q[head] || rfReady);
  assign wr_idx  = head ^ count[0];

  always_comb begin
    entry_valid = '0;
    for (int unsigned e = 0; e < 2; e++) begin
      entry_valid[e] = (count == 2'd2) || ((count == 2'd1) && (head == e[0]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        data_q[wr_idx] <= executionResult;
        dest_q[wr_idx] <= exDest;
        rw_q[wr_idx]   <= exRegWrite;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Carry is committed at acceptance so a stalled drain never delays the next instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_reg <= '0;
    end else if (push && exCarryWrite) begin
      carry_reg <= carryTotal;
    end else if (carryClear) begin
      carry_reg <= '0;
    end
  end

  always_comb begin
    auxCarry = '0;
    for (int unsigned i = 0; i < BITS_DATA; i++) begin
      auxCarry[BITS_DATA-1-i] = carry_reg[i];
    end
  end

  always_comb begin
    rfWriteEnable = (count != 2'd0) && rw_q[head];
    rfWriteAddr   = dest_q[head];
    rfWriteData   = data_q[head];
  end

  always_comb begin
    pendingMask = '0;
    for (int unsigned e = 0; e < 2; e++) begin
      if (entry_valid[e] && rw_q[e]) pendingMask[dest_q[e]] = 1'b1;
    end
  end

endmodule

// File: doc/vector_writeback.md
# vector_writeback

Writeback stage directly downstream of the 8-lane SIMD execution stage. It accepts each 64-bit execution result with its 8 lane carry-outs, holds them in a 2-entry buffer, and drains them into the vector register file write port under a ready handshake. It also owns the architectural per-lane carry flag register that feeds the execution stage's `auxCarry` input.

## Interface
- BITS_ARRAY, 64, result/register width (8 lanes × 8 bits)
- BITS_DATA, 8, lane count; width of the carry vectors
- BITS_ADDR, 3, vector register address width (8 registers)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- exValid  in  1  execution stage presents a valid result this cycle
- exReady  out  1  buffer can accept; transfer occurs when exValid && exReady
- executionResult  in  BITS_ARRAY  lane results; lane i on bits [8i+7:8i]
- carryTotal  in  BITS_DATA  lane carry-outs; bit i = lane i
- exDest  in  BITS_ADDR  destination vector register
- exRegWrite  in  1  result is written to the register file
- exCarryWrite  in  1  carryTotal updates the carry flag register
- carryClear  in  1  clear all carry flags
- auxCarry  out  BITS_DATA  carry-in to execution stage; auxCarry[7-i] = flag of lane i
- rfWriteEnable  out  1  write request to register file
- rfWriteAddr  out  BITS_ADDR  write address
- rfWriteData  out  BITS_ARRAY  write data
- rfReady  in  1  register file accepts write this cycle
- pendingMask  out  2^BITS_ADDR  bit r set while any buffered entry targets register r with regWrite=1

## Operation
- Buffer: 2-entry in-order FIFO of {data, dest, regWrite}; count 0..2.
- exReady = (count != 2); does not depend on rfReady.
- Head entry (count ≥ 1): if regWrite=1, rfWriteEnable=1 with head addr/data; pops on the edge where rfReady=1. If regWrite=0, rfWriteEnable=0 and head pops unconditionally on the next edge.
- Push and pop in the same cycle allowed at count 1 (count stays 1) and count 0 is impossible to pop.
- Carry flag register carryReg[7:0], lane-ordered (bit i = lane i). On an accepted transfer with exCarryWrite=1: carryReg ← carryTotal. Updated at acceptance, not at drain, so the next instruction sees the new carry regardless of register file stalls.
- carryClear=1: carryReg ← 0, unless an accepted transfer with exCarryWrite=1 occurs in the same cycle; the write wins.
- auxCarry is the bit-reversal of carryReg: auxCarry[7-i] = carryReg[i].
- pendingMask: OR over valid entries with regWrite=1 of one-hot(dest); combinational from buffer state.
- exCarryWrite/exRegWrite/exDest/data ignored when exValid=0 or exReady=0.

## Timing
- Reset (synchronous): count=0, carryReg=0 → auxCarry=0x00, rfWriteEnable=0, pendingMask=0, exReady=1 on the cycle after reset is sampled. Inputs are ignored in any cycle with reset=1; reset mid-drain discards both entries without writing.
- Latency: result accepted at edge N appears on rfWrite* during cycle N+1 (count was 0); rfWriteEnable is combinational from registered state, no combinational path from exValid to rf outputs.
- auxCarry reflects a carry write accepted at edge N from cycle N+1.
- Sustained throughput with rfReady=1: one result per cycle.
- rfReady held low: buffer fills after 2 accepts, exReady drops in the cycle after the second accept, and stays low until a pop.
- rfWriteAddr/rfWriteData hold stable while rfWriteEnable=1 and rfReady=0.

## Test plan
- After reset: accept {data=0x0102030405060708, dest=3, regWrite=1}, rfReady=1 → next cycle rfWriteEnable=1, addr=3, data matches, pendingMask=0x08; following cycle rfWriteEnable=0, pendingMask=0.
- Carry write carryTotal=0x01 (lane 0) → auxCarry=0x80 next cycle; carryTotal=0x81 → auxCarry=0x81; carryClear alone → 0x00.
- carryClear=1 with accepted exCarryWrite=1, carryTotal=0x0F → auxCarry=0xF0 (write wins).
- rfReady=0, push dest 1 then dest 2 → exReady=0, pendingMask=0x06, rf outputs hold dest 1; raise rfReady → dest 1 then dest 2 written on consecutive cycles, exReady=1 after first pop.
- regWrite=0 entry between two writes → no rfWriteEnable for it, pops in one cycle, order of remaining writes preserved.
- Reset asserted with count=2 and carryReg=0xFF → next cycle count=0, rfWriteEnable=0, auxCarry=0x00, no write issued.
